mod6_seq_monitor: RTL and testbench

- Downstream consumer of the 3-bit MOD-6 count stream (legal values 0..5, one step per clk).
- Checks that the count follows the legal 0→1→2→3→4→5→0 sequence.
- Emits a one-cycle pulse on every 5→0 wrap and keeps a saturating count of completed cycles.
- Flags sequence errors with a pulse, a sticky flag and a saturating error count, for system-level checking of the counter stage.

---
 rtl/mod6_seq_monitor.sv | 125 ++++++++++++
 tb/tb_mod6_seq_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod6_seq_monitor.sv
// Sequence checker for a MOD-6 count stream: locks on 0, verifies 0..5 stepping,
// pulses on each 5->0 wrap and counts completed cycles and sequence errors.
module mod6_seq_monitor #(
  parameter int CYCLE_W = 8,
  parameter int ERR_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         count_in,
  input  logic               count_valid,
  input  logic               clr_err,
  output logic               locked,
  output logic               wrap_pulse,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               seq_err,
  output logic               err_sticky,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t             r_state;
  logic [2:0]         r_prev;
  logic               r_wrap;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic               r_seq_err;
  logic               r_err_sticky;
  logic [ERR_W-1:0]   r_err_count;

  state_t             w_state_next;
  logic [2:0]         w_prev_next;
  logic               w_wrap_next;
  logic [CYCLE_W-1:0] w_cycle_count_next;
  logic               w_err_next;
  logic               w_err_sticky_next;
  logic [ERR_W-1:0]   w_err_count_next;
  logic [2:0]         w_expected;

  assign w_expected = (r_prev == 3'd5) ? 3'd0 : r_prev + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= SYNC;
      r_prev        <= 3'd0;
      r_wrap        <= 1'b0;
      r_cycle_count <= '0;
      r_seq_err     <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_prev        <= w_prev_next;
      r_wrap        <= w_wrap_next;
      r_cycle_count <= w_cycle_count_next;
      r_seq_err     <= w_err_next;
      r_err_sticky  <= w_err_sticky_next;
      r_err_count   <= w_err_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_prev_next        = r_prev;
    w_wrap_next        = 1'b0;
    w_err_next         = 1'b0;
    w_cycle_count_next = r_cycle_count;
    w_err_sticky_next  = r_err_sticky;
    w_err_count_next   = r_err_count;

    // Values 6/7 are errors in any state and take priority over the sequence check.
    if (count_valid) begin
      if (count_in > 3'd5) begin
        w_err_next   = 1'b1;
        w_state_next = SYNC;
      end else begin
        case (r_state)
          SYNC: begin
            if (count_in == 3'd0) begin
              w_state_next = TRACK;
              w_prev_next  = 3'd0;
            end
          end
          TRACK: begin
            if (count_in == w_expected) begin
              w_prev_next = count_in;
              w_wrap_next = (r_prev == 3'd5);
            end else begin
              w_err_next   = 1'b1;
              w_state_next = SYNC;
            end
          end
          default: w_state_next = SYNC;
        endcase
      end
    end

    if (w_wrap_next && (r_cycle_count != '1)) begin
      w_cycle_count_next = r_cycle_count + CYCLE_W'(1);
    end

    // A fresh error beats a simultaneous clear: the count restarts at one.
    if (w_err_next) begin
      w_err_sticky_next = 1'b1;
      if (clr_err) begin
        w_err_count_next = ERR_W'(1);
      end else if (r_err_count != '1) begin
        w_err_count_next = r_err_count + ERR_W'(1);
      end
    end else if (clr_err) begin
      w_err_sticky_next = 1'b0;
      w_err_count_next  = '0;
    end
  end

  assign locked      = (r_state == TRACK);
  assign wrap_pulse  = r_wrap;
  assign cycle_count = r_cycle_count;
  assign seq_err     = r_seq_err;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_mod6_seq_monitor.sv
// Scoreboard bench for mod6_seq_monitor: directed vectors push hand-derived
// expectations; a monitor pops and compares one clock after each sampled input.
module tb_mod6_seq_monitor;

  localparam int CYCLE_W = 3;
  localparam int ERR_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         count_in;
  logic               count_valid;
  logic               clr_err;
  logic               locked;
  logic               wrap_pulse;
  logic [CYCLE_W-1:0] cycle_count;
  logic               seq_err;
  logic               err_sticky;
  logic [ERR_W-1:0]   err_count;

  mod6_seq_monitor #(.CYCLE_W(CYCLE_W), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .clr_err     (clr_err),
    .locked      (locked),
    .wrap_pulse  (wrap_pulse),
    .cycle_count (cycle_count),
    .seq_err     (seq_err),
    .err_sticky  (err_sticky),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    int   cin;
    logic v;
    logic l;
    logic w;
    logic e;
    logic s;
    int   ec;
    int   cc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input logic v, input int c, input logic clr,
                      input logic el, input logic ew, input logic ee, input logic es,
                      input int ec, input int cc);
    exp_t e;
    @(negedge clk);
    count_valid = v;
    count_in    = 3'(c);
    clr_err     = clr;
    e.id = vec_id; e.cin = c; e.v = v;
    e.l = el; e.w = ew; e.e = ee; e.s = es; e.ec = ec; e.cc = cc;
    q.push_back(e);
    vec_id++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_wrap"},   int'(wrap_pulse), 0);
    chk({tag, "_cycle"},  int'(cycle_count), 0);
    chk({tag, "_seqerr"}, int'(seq_err), 0);
    chk({tag, "_sticky"}, int'(err_sticky), 0);
    chk({tag, "_errcnt"}, int'(err_count), 0);
  endtask

  // Reset asserted between edges; outputs must clear before any further clock edge.
  task automatic reset_async(input string tag);
    @(posedge clk);
    #2;
    reset       = 1'b0;
    count_valid = 1'b0;
    clr_err     = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      $display("vec %0d: v=%0d in=%0d -> locked=%0d wrap=%0d cyc=%0d err=%0d sticky=%0d errcnt=%0d",
               m.id, m.v, m.cin, locked, wrap_pulse, cycle_count, seq_err, err_sticky, err_count);
      chk($sformatf("v%0d_locked", m.id), int'(locked),      int'(m.l));
      chk($sformatf("v%0d_wrap",   m.id), int'(wrap_pulse),  int'(m.w));
      chk($sformatf("v%0d_seqerr", m.id), int'(seq_err),     int'(m.e));
      chk($sformatf("v%0d_sticky", m.id), int'(err_sticky),  int'(m.s));
      chk($sformatf("v%0d_errcnt", m.id), int'(err_count),   m.ec);
      chk($sformatf("v%0d_cycle",  m.id), int'(cycle_count), m.cc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    count_in    = 3'd0;
    count_valid = 1'b0;
    clr_err     = 1'b0;
    #3;
    check_zero("por");
    #9;
    reset = 1'b1;

    // 1: clean lock and one wrap
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, i, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 0, 0, 0, 1);

    // 2: skip error, SYNC ignores 4, relock on 0, then clear
    for (int i = 2; i <= 5; i++) step(1, i, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0, 0, 2);
    step(1, 1, 0, 1, 0, 0, 0, 0, 2);
    step(1, 3, 0, 0, 0, 1, 1, 1, 2);
    step(1, 4, 0, 0, 0, 0, 1, 1, 2);
    step(1, 0, 0, 1, 0, 0, 1, 1, 2);
    step(0, 0, 1, 1, 0, 0, 0, 0, 2);

    // 3: illegal 6, then illegal 7 colliding with clr_err
    step(1, 6, 0, 0, 0, 1, 1, 1, 2);
    step(1, 7, 1, 0, 0, 1, 1, 1, 2);

    // 4: gaps with count_valid=0 and 7 on the bus are ignored
    step(1, 0, 0, 1, 0, 0, 1, 1, 2);
    step(1, 1, 0, 1, 0, 0, 1, 1, 2);
    step(1, 2, 0, 1, 0, 0, 1, 1, 2);
    repeat (3) step(0, 7, 0, 1, 0, 0, 1, 1, 2);
    for (int i = 3; i <= 5; i++) step(1, i, 0, 1, 0, 0, 1, 1, 2);
    step(1, 0, 0, 1, 1, 0, 1, 1, 3);
    step(0, 0, 1, 1, 0, 0, 0, 0, 3);

    // 5: cycle_count saturates at 7, err_count at 15
    reset_async("rst5");
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      for (int i = 1; i <= 5; i++) step(1, i, 0, 1, 0, 0, 0, 0, (k - 1 > 7) ? 7 : k - 1);
      step(1, 0, 0, 1, 1, 0, 0, 0, (k > 7) ? 7 : k);
    end
    for (int k = 1; k <= 17; k++) step(1, 6, 0, 0, 0, 1, 1, (k > 15) ? 15 : k, 7);
    step(0, 7, 0, 0, 0, 0, 1, 15, 7);

    // 6: async reset while locked with cycles and a sticky error
    reset_async("rst6a");
    step(1, 6, 0, 0, 0, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      for (int i = 1; i <= 5; i++) step(1, i, 0, 1, 0, 0, 1, 1, k - 1);
      step(1, 0, 0, 1, 1, 0, 1, 1, k);
    end
    reset_async("rst6b");
    step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    count_valid = 1'b0;
    clr_err     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
